// File: rtl/hash_serializer.sv
// -----------------------------------------------------------------------------
// hash_serializer
//
// Captures a DATA_W-bit hash on a rising edge of `start` and presents it on a
// parallel bus OUT_W bits at a time. Each word is qualified by load_rpi0, which
// is high for HI_CYC cycles and then low for LO_CYC cycles. In ACK_MODE the
// block also waits for a (synchronised) acknowledge level from the Raspberry Pi
// after every low phase before it moves to the next word.
//
// Ports:
//   clk        system clock
//   rst_p      synchronous active-high reset
//   data       hash to transmit, sampled only on the capture edge
//   start      level input; start & ~start_d begins a transfer
//   ack        asynchronous acknowledge, passed through a 2-flop synchroniser
//   abort      synchronous abort back to idle (shreg/part_out/word_idx hold)
//   part_out   current word (top or bottom slice of the shift register)
//   load_rpi0  registered strobe, high while part_out is valid
//   busy       high in every state except idle
//   done       one-cycle pulse after the last word's low phase / acknowledge
//   word_idx   0-based index of the word currently presented
// -----------------------------------------------------------------------------
module hash_serializer #(
  parameter int DATA_W    = 256,
  parameter int OUT_W     = 8,
  parameter int HI_CYC    = 2097152,
  parameter int LO_CYC    = 2097152,
  parameter int MSB_FIRST = 1,
  parameter int ACK_MODE  = 0
) (
  input  logic                                clk,
  input  logic                                rst_p,
  input  logic [DATA_W-1:0]                   data,
  input  logic                                start,
  input  logic                                ack,
  input  logic                                abort,
  output logic [OUT_W-1:0]                    part_out,
  output logic                                load_rpi0,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(DATA_W/OUT_W):0]       word_idx
);

  localparam int N      = DATA_W / OUT_W;
  localparam int IDX_W  = $clog2(N) + 1;
  localparam int PH_MAX = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
  localparam int CNT_W  = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(HI_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(LO_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_LOAD_HI  = 3'd2;
  localparam logic [2:0] S_LOAD_LO  = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Parameter sanity: a partial last word or an empty phase is not supported.
  if ((DATA_W % OUT_W) != 0) begin : g_bad_width
    $error("hash_serializer: DATA_W (%0d) must be a multiple of OUT_W (%0d)", DATA_W, OUT_W);
  end
  if (HI_CYC < 1 || LO_CYC < 1) begin : g_bad_phase
    $error("hash_serializer: HI_CYC and LO_CYC must both be at least 1");
  end

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  ph_cnt;
  logic              start_d;
  logic              ack_s1;
  logic              ack_s2;
  logic              start_edge;
  logic              advance;
  logic              last_word;

  assign start_edge = start & ~start_d;
  assign last_word  = (word_idx == LAST_IDX);

  // The end of a word: either the low phase expires (no handshake) or the
  // synchronised acknowledge level is seen while waiting for it.
  assign advance = ((ACK_MODE == 0) && (state == S_LOAD_LO) && (ph_cnt == LO_LAST)) ||
                   ((state == S_WAIT_ACK) && ack_s2);

  // The output word is always taken from the end of shreg that shifts out first.
  if (MSB_FIRST != 0) begin : g_out_msb
    assign part_out = shreg[DATA_W-1 -: OUT_W];
  end else begin : g_out_lsb
    assign part_out = shreg[OUT_W-1:0];
  end

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = here would let later statements see
  // already-updated state and silently reorder the pipeline.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state     <= S_IDLE;
      shreg     <= '0;
      ph_cnt    <= '0;
      start_d   <= 1'b0;
      ack_s1    <= 1'b0;
      ack_s2    <= 1'b0;
      load_rpi0 <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      word_idx  <= '0;
    end else begin
      // Edge detector and synchroniser run in every state, abort included.
      start_d <= start;
      ack_s1  <= ack;
      ack_s2  <= ack_s1;
      done    <= 1'b0;

      if (abort) begin
        state     <= S_IDLE;
        load_rpi0 <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_edge) begin
              shreg    <= data;
              word_idx <= '0;
              busy     <= 1'b1;
              state    <= S_SETUP;
            end
          end
          S_SETUP: begin
            load_rpi0 <= 1'b1;
            ph_cnt    <= '0;
            state     <= S_LOAD_HI;
          end
          S_LOAD_HI: begin
            if (ph_cnt == HI_LAST) begin
              load_rpi0 <= 1'b0;
              ph_cnt    <= '0;
              state     <= S_LOAD_LO;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
          S_LOAD_LO: begin
            if (ph_cnt != LO_LAST) begin
              ph_cnt <= ph_cnt + 1'b1;
            end else if (ACK_MODE != 0) begin
              state <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            // Leaving is handled by the shared advance logic below.
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state     <= S_IDLE;
            load_rpi0 <= 1'b0;
            busy      <= 1'b0;
          end
        endcase

        // Shared end-of-word step for both the timed and the handshake path;
        // it overrides the state chosen in the case statement above.
        if (advance) begin
          if (last_word) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            shreg    <= (MSB_FIRST != 0) ? (shreg << OUT_W) : (shreg >> OUT_W);
            word_idx <= word_idx + 1'b1;
            state    <= S_SETUP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_serializer.sv
// -----------------------------------------------------------------------------
// tb_hash_serializer
//
// Four instances share one set of inputs:
//   0: 32/8, HI=4 LO=4, MSB first, no handshake
//   1: 32/8, HI=4 LO=4, LSB first, no handshake
//   2: 32/8, HI=4 LO=4, MSB first, acknowledge handshake
//   3:  8/8, HI=2 LO=3, single word
// A timestamp-based model predicts every output of every instance each cycle;
// directed literal checks pin key values of the model.
// -----------------------------------------------------------------------------
module tb_hash_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_p, start, ack, abort;
  logic [31:0] data;

  logic [7:0] a_part, b_part, c_part, d_part;
  logic       a_load, b_load, c_load, d_load;
  logic       a_busy, b_busy, c_busy, d_busy;
  logic       a_done, b_done, c_done, d_done;
  logic [2:0] a_widx, b_widx, c_widx;
  logic       d_widx;

  hash_serializer #(.DATA_W(32), .OUT_W(8), .HI_CYC(4), .LO_CYC(4), .MSB_FIRST(1), .ACK_MODE(0)) u_a (
    .clk(clk), .rst_p(rst_p), .data(data), .start(start), .ack(ack), .abort(abort),
    .part_out(a_part), .load_rpi0(a_load), .busy(a_busy), .done(a_done), .word_idx(a_widx));

  hash_serializer #(.DATA_W(32), .OUT_W(8), .HI_CYC(4), .LO_CYC(4), .MSB_FIRST(0), .ACK_MODE(0)) u_b (
    .clk(clk), .rst_p(rst_p), .data(data), .start(start), .ack(ack), .abort(abort),
    .part_out(b_part), .load_rpi0(b_load), .busy(b_busy), .done(b_done), .word_idx(b_widx));

  hash_serializer #(.DATA_W(32), .OUT_W(8), .HI_CYC(4), .LO_CYC(4), .MSB_FIRST(1), .ACK_MODE(1)) u_c (
    .clk(clk), .rst_p(rst_p), .data(data), .start(start), .ack(ack), .abort(abort),
    .part_out(c_part), .load_rpi0(c_load), .busy(c_busy), .done(c_done), .word_idx(c_widx));

  hash_serializer #(.DATA_W(8), .OUT_W(8), .HI_CYC(2), .LO_CYC(3), .MSB_FIRST(1), .ACK_MODE(0)) u_d (
    .clk(clk), .rst_p(rst_p), .data(data[7:0]), .start(start), .ack(ack), .abort(abort),
    .part_out(d_part), .load_rpi0(d_load), .busy(d_busy), .done(d_done), .word_idx(d_widx));

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int dn[4]    = '{0, 0, 0, 0};   // observed done pulses per instance

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic        s_rst = 1'b0, s_start = 1'b0, s_ack = 1'b0, s_abort = 1'b0;
  logic [31:0] s_data = '0;
  always @(posedge clk) begin
    s_rst   <= rst_p;
    s_start <= start;
    s_ack   <= ack;
    s_abort <= abort;
    s_data  <= data;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: each transfer is a list of words; the current word is
  // described by the edge at which it was set up, and its phases follow from
  // the elapsed cycle count (setup 1, high HI, low LO, then optional wait).
  // ---------------------------------------------------------------------------
  int  n_w[4]  = '{4, 4, 4, 1};
  int  hi_c[4] = '{4, 4, 4, 2};
  int  lo_c[4] = '{4, 4, 4, 3};
  bit  msb[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit  ackm[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  bit          m_act[4], m_donec[4];
  int          m_tw[4], m_widx[4];
  logic [31:0] m_cap[4];
  logic [7:0]  m_part[4];
  bit          m_prev_start, m_ah1, m_ah2, m_valid;
  int          cyc;

  function automatic logic [7:0] word_of(input int i, input logic [31:0] cap, input int k);
    int pos;
    pos = msb[i] ? (n_w[i] - 1 - k) : k;
    return 8'(cap >> (8 * pos));
  endfunction

  initial begin
    m_valid = 0; cyc = 0; m_prev_start = 0; m_ah1 = 0; m_ah2 = 0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0; m_donec[i] = 0; m_tw[i] = 0; m_widx[i] = 0; m_cap[i] = '0; m_part[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (s_rst) m_valid = 1;

      // Advance the model by the rising edge that just happened.
      for (int i = 0; i < 4; i++) begin
        int rel, lo_end;
        bit adv;
        if (s_rst) begin
          m_act[i] = 0; m_donec[i] = 0; m_widx[i] = 0; m_part[i] = '0;
        end else if (s_abort) begin
          m_act[i] = 0; m_donec[i] = 0;
        end else if (m_donec[i]) begin
          m_donec[i] = 0; m_act[i] = 0;
        end else if (!m_act[i]) begin
          if (s_start && !m_prev_start) begin
            m_act[i]  = 1;
            m_cap[i]  = s_data;
            m_widx[i] = 0;
            m_tw[i]   = cyc;
            m_part[i] = word_of(i, s_data, 0);
          end
        end else begin
          rel    = cyc - m_tw[i];
          lo_end = 1 + hi_c[i] + lo_c[i];
          // ack seen by the block now is the pin value two edges ago
          adv = ackm[i] ? (rel > lo_end && m_ah2) : (rel == lo_end);
          if (adv) begin
            if (m_widx[i] == n_w[i] - 1) begin
              m_donec[i] = 1;
            end else begin
              m_widx[i]++;
              m_tw[i]   = cyc;
              m_part[i] = word_of(i, m_cap[i], m_widx[i]);
            end
          end
        end
      end
      if (s_rst) begin
        m_prev_start = 0; m_ah1 = 0; m_ah2 = 0;
      end else begin
        m_prev_start = s_start; m_ah2 = m_ah1; m_ah1 = s_ack;
      end

      // Compare every output of every instance.
      if (m_valid) begin
        for (int i = 0; i < 4; i++) begin
          logic [7:0] p; logic l, b, d; logic [2:0] w;
          int rel;
          bit e_load;
          case (i)
            0:       begin p = a_part; l = a_load; b = a_busy; d = a_done; w = a_widx; end
            1:       begin p = b_part; l = b_load; b = b_busy; d = b_done; w = b_widx; end
            2:       begin p = c_part; l = c_load; b = c_busy; d = c_done; w = c_widx; end
            default: begin p = d_part; l = d_load; b = d_busy; d = d_done; w = {2'b00, d_widx}; end
          endcase
          rel    = cyc - m_tw[i];
          e_load = m_act[i] && !m_donec[i] && rel >= 1 && rel <= hi_c[i];
          check($sformatf("inst%0d part_out", i),  32'(p), 32'(m_part[i]));
          check($sformatf("inst%0d load_rpi0", i), 32'(l), 32'(e_load));
          check($sformatf("inst%0d busy", i),      32'(b), 32'(m_act[i]));
          check($sformatf("inst%0d done", i),      32'(d), 32'(m_donec[i]));
          check($sformatf("inst%0d word_idx", i),  32'(w), 32'(m_widx[i]));
          if (d === 1'b1) dn[i]++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    int cnt, lat;
    rst_p = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    check("reset part_out", 32'(a_part), 32'h0);
    check("reset load", 32'(a_load), 32'h0);
    check("reset busy", 32'(c_busy), 32'h0);
    rst_p = 1'b0;
    @(negedge clk);

    // Plain transfer, both word orders, plus the single-word instance.
    data = 32'hA1B2C3D4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (a_done !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check("msb word0", 32'(a_part), 32'hA1);
        check("lsb word0", 32'(b_part), 32'hD4);
        check("word0 strobe", 32'(a_load), 32'h1);
        check("n1 word", 32'(d_part), 32'hD4);
      end
      if (cnt == 10) begin
        check("msb word1", 32'(a_part), 32'hB2);
        check("lsb word1", 32'(b_part), 32'hC3);
        check("lsb idx1", 32'(b_widx), 32'h1);
      end
      if (cnt == 28) begin
        check("msb word3", 32'(a_part), 32'hD4);
        check("msb idx3", 32'(a_widx), 32'h3);
        check("lsb word3", 32'(b_part), 32'hA1);
      end
    end
    check("done latency", 32'(cnt), 32'd36);
    @(negedge clk);
    check("busy after done", 32'(a_busy), 32'h0);
    check("ack wait busy", 32'(c_busy), 32'h1);
    check("ack wait load", 32'(c_load), 32'h0);
    check("ack wait idx", 32'(c_widx), 32'h0);

    // Acknowledge handshake, one pulse per word.
    for (int w = 0; w < 4; w++) begin
      ack = 1'b1;
      lat = 0;
      while (32'(c_widx) == w && c_done !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("ack latency w%0d", w), 32'(lat >= 2 && lat <= 3), 32'h1);
      repeat (5 - lat) @(negedge clk);
      ack = 1'b0;
      repeat (12) @(negedge clk);
    end
    check("ack done count", 32'(dn[2]), 32'd1);
    check("no-ack done count", 32'(dn[0]), 32'd1);

    // Restart while busy, then start held across the end of the transfer.
    data = 32'hA1B2C3D4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    data = 32'h55667788; start = 1'b1;
    repeat (40) @(negedge clk);
    check("held start part", 32'(a_part), 32'hD4);
    check("held start lsb", 32'(b_part), 32'hA1);
    check("held start idle", 32'(a_busy), 32'h0);
    check("held start one done", 32'(dn[0]), 32'd2);
    start = 1'b0;
    @(negedge clk);

    // Abort during word 2 high phase.
    data = 32'hA1B2C3D4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort load", 32'(a_load), 32'h0);
    check("abort busy", 32'(a_busy), 32'h0);
    check("abort holds idx", 32'(a_widx), 32'h2);
    check("abort holds part", 32'(a_part), 32'hC3);
    repeat (20) @(negedge clk);
    check("abort no done", 32'(dn[0]), 32'd2);

    // Abort and start together while idle: no capture.
    data = 32'h99999999; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort+start idle", 32'(a_busy), 32'h0);
    check("abort+start part", 32'(a_part), 32'hC3);

    data = 32'h11223344; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("fresh msb last", 32'(a_part), 32'h44);
    check("fresh lsb last", 32'(b_part), 32'h11);
    check("fresh done count", 32'(dn[0]), 32'd3);

    // Reset during word 1 low phase, start held through reset release.
    data = 32'hA1B2C3D4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_p = 1'b1; start = 1'b1;
    @(negedge clk);
    check("mid reset part", 32'(a_part), 32'h0);
    check("mid reset load", 32'(a_load), 32'h0);
    check("mid reset busy", 32'(a_busy), 32'h0);
    check("mid reset idx", 32'(a_widx), 32'h0);
    @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
    check("post reset capture", 32'(a_busy), 32'h1);
    check("post reset word", 32'(a_part), 32'hA1);
    repeat (45) @(negedge clk);
    check("post reset done count", 32'(dn[0]), 32'd4);
    start = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hash_serializer.md
Name: hash_serializer

Overview:
- Parametrised successor of the fixed 256-bit to byte hash transmitter.
- Captures a DATA_W-bit hash when a start edge arrives, then presents it on a parallel bus OUT_W bits at a time.
- Each word is qualified by a strobe (load_rpi0) with programmable high and low phase lengths.
- Adds selectable word order, an optional per-word acknowledge handshake from the Raspberry Pi, abort, and busy/done status.

Parameters:
DATA_W, 256, width of the captured hash; must be a multiple of OUT_W, elaboration error otherwise
OUT_W, 8, width of each transmitted word
HI_CYC, 2097152, clk cycles load_rpi0 stays high per word (≥1)
LO_CYC, 2097152, clk cycles load_rpi0 stays low after each high phase (≥1)
MSB_FIRST, 1, 1: first word = data[DATA_W-1 -: OUT_W]; 0: first word = data[OUT_W-1:0]
ACK_MODE, 0, 1: after each low phase, wait for ack before advancing

Ports:
clk  in  1  system clock, 100 MHz
rst_p  in  1  synchronous active-high reset
data  in  DATA_W  hash to transmit; sampled only on the capture edge
start  in  1  level; a rising edge (start & ~start_d) begins a transfer
ack  in  1  asynchronous acknowledge from the RPi; passes through a 2-flop synchroniser inside the block
abort  in  1  synchronous abort; returns the block to IDLE
part_out  out  OUT_W  current word
load_rpi0  out  1  registered strobe; high = part_out valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last word's low phase
word_idx  out  clog2(N)+1  index of the word currently presented, 0-based; N = DATA_W/OUT_W

Behaviour:
- Reset: all outputs 0; state IDLE; start_d=0, so start held high at reset release counts as an edge; synchroniser flops 0; phase counter 0.
- Shift register shreg[DATA_W]: part_out = top word (MSB_FIRST=1) or bottom word (MSB_FIRST=0) of shreg. Each shift moves the next word into the output position and fills zeros behind it.
- Phase counter width: clog2(max(HI_CYC,LO_CYC)+1). It restarts from 0 on every phase entry.
- FSM states: IDLE, SETUP, LOAD_HI, LOAD_LO, WAIT_ACK, DONE.
  - IDLE: on a start edge at clock edge T: shreg<=data, word_idx<=0, go SETUP. Otherwise stay.
  - SETUP: exactly 1 cycle, with part_out already stable; then go LOAD_HI. load_rpi0 is set on this same edge.
  - LOAD_HI: load_rpi0=1 for exactly HI_CYC cycles, then go LOAD_LO and clear load_rpi0.
  - LOAD_LO: load_rpi0=0 for exactly LO_CYC cycles. At the end:
    - ACK_MODE=1 → WAIT_ACK.
    - ACK_MODE=0, last word (word_idx==N-1) → DONE.
    - ACK_MODE=0, otherwise → shift shreg, word_idx++, go SETUP.
  - WAIT_ACK: wait indefinitely for synchronised ack==1 (level, not edge). Then apply the same last-word/advance rule as LOAD_LO.
    - The bench must drop ack before the next WAIT_ACK. An ack still high on re-entry is accepted immediately.
  - DONE: done=1 for one cycle, busy=1, then go IDLE. busy=0 from the following cycle.
- Timing for ACK_MODE=0, capture at edge T:
  - load_rpi0 is high after edges T+1 .. T+HI_CYC.
  - Word period is 1+HI_CYC+LO_CYC cycles.
  - done is high in cycle T + N*(1+HI_CYC+LO_CYC).
- part_out is unchanged during SETUP, LOAD_HI and LOAD_LO of a word. It changes only on the shift edge.
  - After DONE, it holds the last word until the next capture.
- Boundary conditions:
  - start edge while busy: ignored; start_d still tracks start.
  - start held high: exactly one transfer.
  - start edge in the DONE cycle: ignored.
  - abort: has priority over everything except reset. At the next edge: state=IDLE, load_rpi0=0, busy=0, done=0; shreg/part_out/word_idx hold.
  - abort and start together while IDLE: abort wins, no capture.
  - rst_p mid-transfer: immediate return to the reset values above.
  - N=1: a single word, then DONE.

Test Plan:
1. DATA_W=32, OUT_W=8, HI_CYC=4, LO_CYC=4, MSB_FIRST=1, ACK_MODE=0; data=0xA1B2C3D4, start pulse → part_out A1,B2,C3,D4, each stable with load_rpi0 high for 4 cycles; word period 9 cycles; done pulses once, 36 cycles after the capture edge; busy falls the cycle after done.
2. Same parameters with MSB_FIRST=0 → order D4,C3,B2,A1; word_idx counts 0..3.
3. ACK_MODE=1; ack held low → block stays in WAIT_ACK after word 0 with load_rpi0=0. Raise ack for 5 cycles, drop, repeat per word → next SETUP follows 2–3 cycles after ack rises; 4 words, then done.
4. Second start edge mid-transfer (word 1), and start held high across the end of the transfer → no recapture, no second transfer; part_out remains 0xD4 afterwards.
5. abort asserted during word 2 LOAD_HI → next cycle load_rpi0=0, busy=0, no done. A fresh start edge with data=0x11223344 → clean transfer 11,22,33,44.
6. rst_p pulsed during LOAD_LO of word 1 → all outputs 0 the next cycle. start held high through reset release → one transfer begins on the first post-reset cycle.
